// File: rtl/ddr4_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ddr4_mon_pkg
// Brief    : Shared command codes, opcodes and error-bit indices.
// Revision : 1.0  initial release
// ============================================================================
package ddr4_mon_pkg;

    typedef enum logic [3:0] {
        CMD_MRS = 4'd0,
        CMD_REF = 4'd1,
        CMD_PRE = 4'd2,
        CMD_RSV = 4'd3,
        CMD_WR  = 4'd4,
        CMD_RD  = 4'd5,
        CMD_ZQC = 4'd6,
        CMD_ACT = 4'd8
    } cmd_e;

    // RAS_n/CAS_n/WE_n on adr[16:14] when ACT_n is high
    localparam logic [2:0] c_op_mrs = 3'b000;
    localparam logic [2:0] c_op_ref = 3'b001;
    localparam logic [2:0] c_op_pre = 3'b010;
    localparam logic [2:0] c_op_rsv = 3'b011;
    localparam logic [2:0] c_op_wr  = 3'b100;
    localparam logic [2:0] c_op_rd  = 3'b101;
    localparam logic [2:0] c_op_zqc = 3'b110;
    localparam logic [2:0] c_op_nop = 3'b111;

    localparam int c_err_act_open = 0;
    localparam int c_err_rw_closed = 1;
    localparam int c_err_ref_open = 2;
    localparam int c_err_rsv = 3;
    localparam int c_err_cs_cke = 4;

endpackage : ddr4_mon_pkg
`default_nettype wire

// File: rtl/ddr4_cmd_monitor_if.sv
`default_nettype none
// ============================================================================
// Interface : ddr4_cmd_monitor_if
// Brief     : DDR4 command/address pin bundle seen by the monitor.
// Revision  : 1.0  initial release
// ============================================================================
interface ddr4_cmd_monitor_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int RANK_WIDTH = 1,
    parameter int BG_WIDTH   = 1,
    parameter int BA_WIDTH   = 2
);
    logic                  ddr4_reset_n;
    logic                  ddr4_cke;
    logic [RANK_WIDTH-1:0] ddr4_cs_n;
    logic                  ddr4_act_n;
    logic [ADDR_WIDTH-1:0] ddr4_adr;
    logic [BA_WIDTH-1:0]   ddr4_ba;
    logic [BG_WIDTH-1:0]   ddr4_bg;

    modport master (
        output ddr4_reset_n, ddr4_cke, ddr4_cs_n, ddr4_act_n,
               ddr4_adr, ddr4_ba, ddr4_bg
    );

    modport slave (
        input  ddr4_reset_n, ddr4_cke, ddr4_cs_n, ddr4_act_n,
               ddr4_adr, ddr4_ba, ddr4_bg
    );
endinterface : ddr4_cmd_monitor_if
`default_nettype wire

// File: rtl/ddr4_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_bank_tracker
// Brief    : Open-bank bitmap for one rank; per-rank checks under
//            DDR4_MON_ERR_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ddr4_bank_tracker
    import ddr4_mon_pkg::*;
#(
    parameter int  BG_WIDTH = 1,
    parameter int  BA_WIDTH = 2,
    localparam int BANKS    = 1 << (BG_WIDTH + BA_WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_dram_rst,
    input  logic                i_cmd_en,
    input  cmd_e                i_cmd,
    input  logic [BG_WIDTH-1:0] i_bg,
    input  logic [BA_WIDTH-1:0] i_ba,
    input  logic                i_pre_all,
    output logic [BANKS-1:0]    o_bank_open
`ifdef DDR4_MON_ERR_CHECK_EN
    ,
    output logic [2:0]          o_err
`endif
);

    logic [BG_WIDTH+BA_WIDTH-1:0] w_idx;
    logic [BANKS-1:0]             r_open;

    assign w_idx       = {i_bg, i_ba};
    assign o_bank_open = r_open;

    always_ff @(posedge clk) begin
        if (rst || i_dram_rst) begin
            r_open <= '0;
        end else if (i_cmd_en) begin
            case (i_cmd)
                CMD_ACT: r_open[w_idx] <= 1'b1;
                CMD_PRE: begin
                    if (i_pre_all) r_open <= '0;
                    else           r_open[w_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DDR4_MON_ERR_CHECK_EN
    // Checks look at the bitmap before this command's update lands
    always_comb begin
        o_err = '0;
        if (i_cmd_en) begin
            o_err[c_err_act_open]  = (i_cmd == CMD_ACT) && r_open[w_idx];
            o_err[c_err_rw_closed] = ((i_cmd == CMD_WR) || (i_cmd == CMD_RD)) && !r_open[w_idx];
            o_err[c_err_ref_open]  = (i_cmd == CMD_REF) && (|r_open);
        end
    end
`endif

endmodule : ddr4_bank_tracker
`default_nettype wire

// File: rtl/ddr4_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_cmd_monitor
// Brief    : Registered DDR4 command decoder with per-rank bank tracking,
//            direction and saturating counters. Define DDR4_MON_ERR_CHECK_EN
//            to add the sticky err_flags protocol checks.
// Revision : 1.0  initial release
// ============================================================================
module ddr4_cmd_monitor
    import ddr4_mon_pkg::*;
#(
    parameter int    ADDR_WIDTH = 17,
    parameter int    RANK_WIDTH = 1,
    parameter int    BG_WIDTH   = 1,
    parameter int    BA_WIDTH   = 2,
    parameter string CA_MIRROR  = "OFF",
    parameter int    CNT_WIDTH  = 32,
    localparam int   RANK_IDX_W = (RANK_WIDTH > 1) ? $clog2(RANK_WIDTH) : 1,
    localparam int   BANKS      = 1 << (BG_WIDTH + BA_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    ddr4_cmd_monitor_if.slave           bus,
    input  logic                        clr_cnt,
    output logic                        cmd_valid,
    output logic [3:0]                  cmd_code,
    output logic [RANK_IDX_W-1:0]       cmd_rank,
    output logic [BG_WIDTH-1:0]         cmd_bg,
    output logic [BA_WIDTH-1:0]         cmd_ba,
    output logic [ADDR_WIDTH-1:0]       cmd_adr,
    output logic [RANK_WIDTH*BANKS-1:0] bank_open,
    output logic                        last_dir,
    output logic [CNT_WIDTH-1:0]        cnt_act,
    output logic [CNT_WIDTH-1:0]        cnt_rd,
    output logic [CNT_WIDTH-1:0]        cnt_wr,
    output logic [CNT_WIDTH-1:0]        cnt_ref
`ifdef DDR4_MON_ERR_CHECK_EN
    ,
    output logic [4:0]                  err_flags
`endif
);

    localparam bit c_mirror_en = (CA_MIRROR == "ON");

    logic [RANK_WIDTH-1:0] w_cs_sel;
    logic                  w_any_sel;
    logic [2:0]            w_op;
    cmd_e                  w_cmd;
    logic                  w_is_cmd;
    logic                  w_valid;
    logic [RANK_IDX_W-1:0] w_low;
    logic                  w_low_odd;
    logic [ADDR_WIDTH-1:0] w_adr_mir;
    logic [BA_WIDTH-1:0]   w_ba_mir;

    assign w_cs_sel  = ~bus.ddr4_cs_n;
    assign w_any_sel = |w_cs_sel;
    assign w_op      = bus.ddr4_adr[16:14];
    assign w_valid   = bus.ddr4_reset_n && bus.ddr4_cke && w_any_sel && w_is_cmd;

    always_comb begin
        w_cmd    = CMD_MRS;
        w_is_cmd = 1'b1;
        if (!bus.ddr4_act_n) begin
            w_cmd = CMD_ACT;
        end else begin
            case (w_op)
                c_op_mrs: w_cmd = CMD_MRS;
                c_op_ref: w_cmd = CMD_REF;
                c_op_pre: w_cmd = CMD_PRE;
                c_op_rsv: w_cmd = CMD_RSV;
                c_op_wr:  w_cmd = CMD_WR;
                c_op_rd:  w_cmd = CMD_RD;
                c_op_zqc: w_cmd = CMD_ZQC;
                c_op_nop: w_is_cmd = 1'b0;
            endcase
        end
    end

    // Descending scan so the lowest selected rank is the last write
    always_comb begin
        w_low = '0;
        for (int r = RANK_WIDTH - 1; r >= 0; r--) begin
            if (w_cs_sel[r]) w_low = RANK_IDX_W'(r);
        end
    end

    assign w_low_odd = c_mirror_en && w_low[0];

    // Odd ranks see address/BA pairs swapped on the board; undo that here
    always_comb begin
        w_adr_mir     = bus.ddr4_adr;
        w_adr_mir[3]  = bus.ddr4_adr[4];
        w_adr_mir[4]  = bus.ddr4_adr[3];
        w_adr_mir[5]  = bus.ddr4_adr[6];
        w_adr_mir[6]  = bus.ddr4_adr[5];
        w_adr_mir[7]  = bus.ddr4_adr[8];
        w_adr_mir[8]  = bus.ddr4_adr[7];
        w_adr_mir[11] = bus.ddr4_adr[13];
        w_adr_mir[13] = bus.ddr4_adr[11];
    end

    always_comb begin
        w_ba_mir    = bus.ddr4_ba;
        w_ba_mir[0] = bus.ddr4_ba[1];
        w_ba_mir[1] = bus.ddr4_ba[0];
    end

`ifdef DDR4_MON_ERR_CHECK_EN
    logic [RANK_WIDTH-1:0][2:0] w_rank_err;
    logic [4:0]                 w_err_set;
`endif

    for (genvar r = 0; r < RANK_WIDTH; r++) begin : g_rank
        logic [BA_WIDTH-1:0] w_rank_ba;

        if (c_mirror_en && (r % 2 == 1)) begin : g_mir
            assign w_rank_ba = w_ba_mir;
        end else begin : g_std
            assign w_rank_ba = bus.ddr4_ba;
        end

        ddr4_bank_tracker #(
            .BG_WIDTH (BG_WIDTH),
            .BA_WIDTH (BA_WIDTH)
        ) u_tracker (
            .clk         (clk),
            .rst         (rst),
            .i_dram_rst  (!bus.ddr4_reset_n),
            .i_cmd_en    (w_valid && w_cs_sel[r]),
            .i_cmd       (w_cmd),
            .i_bg        (bus.ddr4_bg),
            .i_ba        (w_rank_ba),
            .i_pre_all   (bus.ddr4_adr[10]),
            .o_bank_open (bank_open[r*BANKS +: BANKS])
`ifdef DDR4_MON_ERR_CHECK_EN
            ,
            .o_err       (w_rank_err[r])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_rank  <= '0;
            cmd_bg    <= '0;
            cmd_ba    <= '0;
            cmd_adr   <= '0;
            last_dir  <= 1'b0;
        end else begin
            cmd_valid <= w_valid;
            if (w_valid) begin
                cmd_code <= w_cmd;
                cmd_rank <= w_low;
                cmd_bg   <= bus.ddr4_bg;
                cmd_ba   <= w_low_odd ? w_ba_mir  : bus.ddr4_ba;
                cmd_adr  <= w_low_odd ? w_adr_mir : bus.ddr4_adr;
            end
            if (!bus.ddr4_reset_n)                 last_dir <= 1'b0;
            else if (w_valid && (w_cmd == CMD_WR)) last_dir <= 1'b1;
            else if (w_valid && (w_cmd == CMD_RD)) last_dir <= 1'b0;
        end
    end

    // One count per command regardless of how many ranks it hit
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_act <= '0;
            cnt_rd  <= '0;
            cnt_wr  <= '0;
            cnt_ref <= '0;
        end else if (w_valid) begin
            if ((w_cmd == CMD_ACT) && (cnt_act != '1)) cnt_act <= cnt_act + CNT_WIDTH'(1);
            if ((w_cmd == CMD_RD)  && (cnt_rd  != '1)) cnt_rd  <= cnt_rd  + CNT_WIDTH'(1);
            if ((w_cmd == CMD_WR)  && (cnt_wr  != '1)) cnt_wr  <= cnt_wr  + CNT_WIDTH'(1);
            if ((w_cmd == CMD_REF) && (cnt_ref != '1)) cnt_ref <= cnt_ref + CNT_WIDTH'(1);
        end
    end

`ifdef DDR4_MON_ERR_CHECK_EN
    always_comb begin
        w_err_set = '0;
        for (int r = 0; r < RANK_WIDTH; r++) begin
            w_err_set[2:0] = w_err_set[2:0] | w_rank_err[r];
        end
        w_err_set[c_err_rsv]    = w_valid && (w_cmd == CMD_RSV);
        w_err_set[c_err_cs_cke] = w_any_sel && !bus.ddr4_cke;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) err_flags <= '0;
        else                err_flags <= err_flags | w_err_set;
    end
`endif

endmodule : ddr4_cmd_monitor
`default_nettype wire

// File: tb/tb_ddr4_cmd_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_cmd_monitor
// Brief    : Two-rank, mirrored, 4-bit-counter bench with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr4_cmd_monitor;

    localparam int ADDR_WIDTH = 17;
    localparam int RANK_WIDTH = 2;
    localparam int BG_WIDTH   = 1;
    localparam int BA_WIDTH   = 2;
    localparam int CNT_WIDTH  = 4;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic        clk;
    logic        rst;
    logic        clr_cnt;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [0:0]  cmd_rank;
    logic [0:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [16:0] cmd_adr;
    logic [15:0] bank_open;
    logic        last_dir;
    logic [3:0]  cnt_act, cnt_rd, cnt_wr, cnt_ref;
`ifdef DDR4_MON_ERR_CHECK_EN
    logic [4:0]  err_flags;
`endif

    ddr4_cmd_monitor_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RANK_WIDTH (RANK_WIDTH),
        .BG_WIDTH   (BG_WIDTH),
        .BA_WIDTH   (BA_WIDTH)
    ) bus_if ();

    ddr4_cmd_monitor #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RANK_WIDTH (RANK_WIDTH),
        .BG_WIDTH   (BG_WIDTH),
        .BA_WIDTH   (BA_WIDTH),
        .CA_MIRROR  ("ON"),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.slave),
        .clr_cnt   (clr_cnt),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_rank  (cmd_rank),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_adr   (cmd_adr),
        .bank_open (bank_open),
        .last_dir  (last_dir),
        .cnt_act   (cnt_act),
        .cnt_rd    (cnt_rd),
        .cnt_wr    (cnt_wr),
        .cnt_ref   (cnt_ref)
`ifdef DDR4_MON_ERR_CHECK_EN
        ,
        .err_flags (err_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference state: which banks are open, direction, counts, sticky errors
    bit       m_open [2][8];
    bit       m_dir;
    int       m_act, m_rd, m_wr, m_ref;
    bit [4:0] m_err;

    function automatic bit [16:0] unmirror(input bit [16:0] a);
        int pairs [4][2] = '{'{3, 4}, '{5, 6}, '{7, 8}, '{11, 13}};
        bit [16:0] res = a;
        for (int p = 0; p < 4; p++) begin
            res[pairs[p][0]] = a[pairs[p][1]];
            res[pairs[p][1]] = a[pairs[p][0]];
        end
        return res;
    endfunction

    function automatic bit [1:0] swap_ba(input bit [1:0] b);
        return {b[0], b[1]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic step(input bit i_rst, input bit rn, input bit cke, input bit [1:0] cs_n,
                        input bit act_n, input bit [16:0] adr, input bit [1:0] ba,
                        input bit bg, input bit clr);
        bit        e_valid = 0;
        int        e_code  = 0;
        int        e_rank  = 0;
        bit [1:0]  e_ba    = 0;
        bit [16:0] e_adr   = 0;
        bit [4:0]  e_new   = 0;
        bit [15:0] e_bo;
        bit        any_sel = (cs_n != 2'b11);
        int        code    = -1;

        rst                 = i_rst;
        bus_if.ddr4_reset_n = rn;
        bus_if.ddr4_cke     = cke;
        bus_if.ddr4_cs_n    = cs_n;
        bus_if.ddr4_act_n   = act_n;
        bus_if.ddr4_adr     = adr;
        bus_if.ddr4_ba      = ba;
        bus_if.ddr4_bg      = bg;
        clr_cnt             = clr;

        if (i_rst) begin
            foreach (m_open[r, i]) m_open[r][i] = 0;
            m_dir = 0; m_act = 0; m_rd = 0; m_wr = 0; m_ref = 0; m_err = 0;
        end else begin
            if (any_sel && !cke) e_new[4] = 1;
            if (!rn) begin
                foreach (m_open[r, i]) m_open[r][i] = 0;
                m_dir = 0;
            end else if (cke && any_sel) begin
                if (!act_n)                code = 8;
                else if (adr[16:14] != 3'd7) code = int'(adr[16:14]);
                if (code >= 0) begin
                    e_valid = 1;
                    e_code  = code;
                    e_rank  = cs_n[0] ? 1 : 0;
                    e_ba    = (e_rank == 1) ? swap_ba(ba) : ba;
                    e_adr   = (e_rank == 1) ? unmirror(adr) : adr;
                    for (int r = 0; r < 2; r++) begin
                        if (!cs_n[r]) begin
                            int rba = (r == 1) ? int'(swap_ba(ba)) : int'(ba);
                            int idx = int'(bg) * 4 + rba;
                            bit any_open = 0;
                            for (int i = 0; i < 8; i++) any_open |= m_open[r][i];
                            case (code)
                                8: begin
                                    if (m_open[r][idx]) e_new[0] = 1;
                                    m_open[r][idx] = 1;
                                end
                                2: begin
                                    if (adr[10]) for (int i = 0; i < 8; i++) m_open[r][i] = 0;
                                    else         m_open[r][idx] = 0;
                                end
                                4, 5: if (!m_open[r][idx]) e_new[1] = 1;
                                1: if (any_open) e_new[2] = 1;
                                default: ;
                            endcase
                        end
                    end
                    if (code == 3) e_new[3] = 1;
                    if (code == 4) m_dir = 1;
                    if (code == 5) m_dir = 0;
                    if (code == 8) m_act = sat_inc(m_act);
                    if (code == 5) m_rd  = sat_inc(m_rd);
                    if (code == 4) m_wr  = sat_inc(m_wr);
                    if (code == 1) m_ref = sat_inc(m_ref);
                end
            end
            m_err |= e_new;
            if (clr) begin
                m_act = 0; m_rd = 0; m_wr = 0; m_ref = 0; m_err = 0;
            end
        end

        @(posedge clk);
        #1;
        check("cmd_valid", 64'(cmd_valid), 64'(e_valid));
        if (e_valid || i_rst) begin
            check("cmd_code", 64'(cmd_code), 64'(e_code));
            check("cmd_rank", 64'(cmd_rank), 64'(e_rank));
            check("cmd_bg",   64'(cmd_bg),   64'(e_valid ? bg : 1'b0));
            check("cmd_ba",   64'(cmd_ba),   64'(e_ba));
            check("cmd_adr",  64'(cmd_adr),  64'(e_adr));
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) e_bo[r*8+i] = m_open[r][i];
        check("bank_open", 64'(bank_open), 64'(e_bo));
        check("last_dir",  64'(last_dir),  64'(m_dir));
        check("cnt_act",   64'(cnt_act),   64'(m_act));
        check("cnt_rd",    64'(cnt_rd),    64'(m_rd));
        check("cnt_wr",    64'(cnt_wr),    64'(m_wr));
        check("cnt_ref",   64'(cnt_ref),   64'(m_ref));
`ifdef DDR4_MON_ERR_CHECK_EN
        check("err_flags", 64'(err_flags), 64'(m_err));
`endif
    endtask

    localparam bit [16:0] A_PRE_ALL = 17'h08400;
    localparam bit [16:0] A_WR      = 17'h10000;
    localparam bit [16:0] A_RD      = 17'h14000;
    localparam bit [16:0] A_REF     = 17'h04000;
    localparam bit [16:0] A_NOP     = 17'h1C000;

    initial begin
        step(1, 1, 1, 2'b11, 1, A_NOP, 0, 0, 0);
        step(1, 1, 1, 2'b11, 1, A_NOP, 0, 0, 0);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_bank_open", 64'(bank_open), 64'd0);
        check("rst_cnt_act", 64'(cnt_act), 64'd0);

        // ACT then RD on rank0 bg1 ba2
        step(0, 1, 1, 2'b10, 0, 17'h00123, 2'd2, 1, 0);
        check("tp1_act_code", 64'(cmd_code), 64'd8);
        step(0, 1, 1, 2'b10, 1, A_RD, 2'd2, 1, 0);
        check("tp1_rd_code", 64'(cmd_code), 64'd5);
        check("tp1_bank6", 64'(bank_open[6]), 64'd1);
        check("tp1_last_dir", 64'(last_dir), 64'd0);
        check("tp1_cnt_act", 64'(cnt_act), 64'd1);
        check("tp1_cnt_rd", 64'(cnt_rd), 64'd1);

        // Mirrored ACT on rank1
        step(0, 1, 1, 2'b01, 0, 17'h00010, 2'b01, 0, 0);
        check("tp2_adr", 64'(cmd_adr), 64'h8);
        check("tp2_ba", 64'(cmd_ba), 64'd2);
        check("tp2_rank", 64'(cmd_rank), 64'd1);

        // Three more banks on rank0, then precharge-all on rank0
        step(0, 1, 1, 2'b10, 0, 17'h0, 2'd0, 0, 0);
        step(0, 1, 1, 2'b10, 0, 17'h0, 2'd1, 0, 0);
        step(0, 1, 1, 2'b10, 0, 17'h0, 2'd3, 0, 0);
        step(0, 1, 1, 2'b10, 1, A_PRE_ALL, 2'd0, 0, 0);
        check("tp3_rank0", 64'(bank_open[7:0]), 64'h0);
        check("tp3_rank1", 64'(bank_open[15:8]), 64'h04);

        // WR to closed bank, then REF with a bank open
        step(0, 1, 1, 2'b11, 1, A_NOP, 0, 0, 1);
        step(0, 1, 1, 2'b10, 1, A_WR, 2'd0, 0, 0);
        step(0, 1, 1, 2'b10, 0, 17'h0, 2'd0, 0, 0);
        step(0, 1, 1, 2'b10, 1, A_REF, 2'd0, 0, 0);
`ifdef DDR4_MON_ERR_CHECK_EN
        check("tp4_err", 64'(err_flags), 64'b00110);
`endif
        step(0, 1, 1, 2'b11, 1, A_NOP, 0, 0, 1);
`ifdef DDR4_MON_ERR_CHECK_EN
        check("tp4_err_clr", 64'(err_flags), 64'd0);
`endif

        // Write counter saturation, then clear racing a WR
        for (int i = 0; i < 17; i++) step(0, 1, 1, 2'b10, 1, A_WR, 2'd0, 0, 0);
        check("tp5_cnt_sat", 64'(cnt_wr), 64'd15);
        step(0, 1, 1, 2'b10, 1, A_WR, 2'd0, 0, 1);
        check("tp5_cnt_clr", 64'(cnt_wr), 64'd0);
        check("tp5_last_dir", 64'(last_dir), 64'd1);

        // ACT while clock enable is low
        step(0, 1, 0, 2'b10, 0, 17'h0, 2'd1, 1, 0);
        check("tp6_valid", 64'(cmd_valid), 64'd0);
        check("tp6_bank5", 64'(bank_open[5]), 64'd0);
`ifdef DDR4_MON_ERR_CHECK_EN
        check("tp6_err4", 64'(err_flags[4]), 64'd1);
`endif

        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 99) != 0,
                 $urandom_range(0, 19) != 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0,
                 17'($urandom),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ddr4_cmd_monitor
`default_nettype wire
